// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolution unit: funct3 encodings and the result record.
package bru_pkg;

    localparam int unsigned BRU_XLEN = 32;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } bru_funct3_e;

    // Address fields are sized for the RV32 pipeline this unit serves.
    typedef struct packed {
        logic                taken;
        logic [BRU_XLEN-1:0] target;
        logic [BRU_XLEN-1:0] redirect_pc;
        logic                mispredict;
        logic                illegal;
    } bru_result_t;

endpackage

// File: rtl/bru_cmp.sv
// Combinational branch condition evaluator: resolves direction and flags reserved funct3 codes.
module bru_cmp
    import bru_pkg::*;
#(
    parameter int unsigned XLEN = BRU_XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_taken,
    output logic            o_illegal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_a == i_b);
    assign w_lt  = ($signed(i_a) < $signed(i_b));
    assign w_ltu = (i_a < i_b);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            BR_EQ:   o_taken = w_eq;
            BR_NE:   o_taken = !w_eq;
            BR_LT:   o_taken = w_lt;
            BR_GE:   o_taken = !w_lt;
            BR_LTU:  o_taken = w_ltu;
            BR_GEU:  o_taken = !w_ltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with a single-entry valid/ready result register and flush.
// Define BRU_PERF_CNT_EN to add saturating branch/mispredict counters (perf_* ports).
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned XLEN = BRU_XLEN
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_illegal
`ifdef BRU_PERF_CNT_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
`endif
);

    logic        r_valid;
    bru_result_t r_res;
    bru_result_t w_res;
    logic        w_taken;
    logic        w_illegal;
    logic        w_ready;
    logic        w_accept;
    logic        w_retire;
    logic [XLEN-1:0] w_target;

    bru_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .i_funct3 (in_funct3),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_taken  (w_taken),
        .o_illegal(w_illegal)
    );

    assign w_ready  = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && w_ready;
    assign w_retire = r_valid && out_ready && !flush;
    assign w_target = in_pc + in_imm;

    always_comb begin
        w_res             = '0;
        w_res.taken       = w_taken;
        w_res.target      = w_target;
        w_res.redirect_pc = w_taken ? w_target : (in_pc + XLEN'(4));
        w_res.mispredict  = (w_taken != in_pred_taken) && !w_illegal;
        w_res.illegal     = w_illegal;
    end

    // Flush outranks accept/retire; the held payload is left in place but invalidated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
        end else if (w_retire) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready        = w_ready;
    assign out_valid       = r_valid;
    assign out_taken       = r_res.taken;
    assign out_target      = r_res.target;
    assign out_redirect_pc = r_res.redirect_pc;
    assign out_mispredict  = r_res.mispredict;
    assign out_illegal     = r_res.illegal;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] r_branches;
    logic [CNT_W-1:0] r_mispredicts;

    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (w_retire && !r_res.illegal) begin
            if (r_branches != '1) begin
                r_branches <= r_branches + CNT_W'(1);
            end
            if (r_res.mispredict && (r_mispredicts != '1)) begin
                r_mispredicts <= r_mispredicts + CNT_W'(1);
            end
        end
    end

    assign perf_branches    = r_branches;
    assign perf_mispredicts = r_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit against a behavioural reference model.
// Exercises the perf counters (CNT_W=4) when BRU_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_redirect_pc;
    logic        out_mispredict;
    logic        out_illegal;
`ifdef BRU_PERF_CNT_EN
    logic                perf_clr;
    logic [TB_CNT_W-1:0] perf_branches;
    logic [TB_CNT_W-1:0] perf_mispredicts;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic        m_valid;
    logic        m_tk;
    logic        m_il;
    logic        m_mp;
    logic [31:0] m_tgt;
    logic [31:0] m_rd;
    int          m_br;
    int          m_mpc;

    always #5 clk = !clk;

    branch_resolve_unit #(
        .XLEN(32)
`ifdef BRU_PERF_CNT_EN
        ,
        .CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_funct3      (in_funct3),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_redirect_pc(out_redirect_pc),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_clr        (perf_clr),
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch semantics from first principles: signed via int, unsigned via 64-bit magnitude.
    function automatic void ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] pc,
                                       input logic [31:0] imm, input logic pred,
                                       output logic tk, output logic il, output logic mp,
                                       output logic [31:0] tgt, output logic [31:0] rd);
        int     sa;
        int     sb;
        longint ua;
        longint ub;
        sa = int'(a);
        sb = int'(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        il = (f3 == 3'd2) || (f3 == 3'd3);
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = (sa < sb);
            3'd5:    tk = (sa >= sb);
            3'd6:    tk = (ua < ub);
            3'd7:    tk = (ua >= ub);
            default: tk = 1'b0;
        endcase
        tgt = pc + imm;
        rd  = tk ? tgt : pc + 32'd4;
        mp  = !il && (tk != pred);
    endfunction

    // One clock: check in_ready, advance the model, then check registered outputs after the edge.
    task automatic cycle();
        logic        exp_ready;
        logic        acc;
        logic        ret;
        logic        tk;
        logic        il;
        logic        mp;
        logic [31:0] tgt;
        logic [31:0] rd;
        #1;
        exp_ready = !flush && (!m_valid || out_ready);
        if (rst_n) check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = in_valid && exp_ready;
        ret = m_valid && out_ready && !flush;
        ref_branch(in_funct3, in_a, in_b, in_pc, in_imm, in_pred_taken, tk, il, mp, tgt, rd);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_tk = 1'b0; m_il = 1'b0; m_mp = 1'b0; m_tgt = '0; m_rd = '0;
            m_br = 0; m_mpc = 0;
        end else begin
`ifdef BRU_PERF_CNT_EN
            if (perf_clr) begin
                m_br = 0;
                m_mpc = 0;
            end else if (ret && !m_il) begin
                if (m_br < CNT_MAX) m_br++;
                if (m_mp && m_mpc < CNT_MAX) m_mpc++;
            end
`endif
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_tk = tk; m_il = il; m_mp = mp; m_tgt = tgt; m_rd = rd;
            end else if (ret) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_taken", 64'(out_taken), 64'(m_tk));
            check_eq("out_illegal", 64'(out_illegal), 64'(m_il));
            check_eq("out_mispredict", 64'(out_mispredict), 64'(m_mp));
            check_eq("out_target", 64'(out_target), 64'(m_tgt));
            check_eq("out_redirect_pc", 64'(out_redirect_pc), 64'(m_rd));
        end
`ifdef BRU_PERF_CNT_EN
        check_eq("perf_branches", 64'(perf_branches), 64'(m_br));
        check_eq("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mpc));
`endif
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid = 1'b1; in_funct3 = f3; in_a = a; in_b = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
        m_valid = 1'b0; m_tk = 1'b0; m_il = 1'b0; m_mp = 1'b0; m_tgt = '0; m_rd = '0;
        m_br = 0; m_mpc = 0;
`ifdef BRU_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        cycle(); cycle();
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_target", 64'(out_target), 64'(0));
        check_eq("rst_redirect", 64'(out_redirect_pc), 64'(0));
        check_eq("rst_flags", 64'({out_taken, out_mispredict, out_illegal}), 64'(0));
        rst_n = 1'b1;
        cycle();

        // BLT with signed -1 < 1
        set_br(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        cycle();
        in_valid = 1'b0;
        check_eq("blt_taken", 64'(out_taken), 64'(1));
        check_eq("blt_target", 64'(out_target), 64'(32'h120));
        check_eq("blt_redirect", 64'(out_redirect_pc), 64'(32'h120));
        check_eq("blt_mispredict", 64'(out_mispredict), 64'(1));
        out_ready = 1'b1;
        cycle();

        // BLTU: 0xFFFFFFFF is not below 1
        set_br(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        cycle();
        in_valid = 1'b0;
        check_eq("bltu_taken", 64'(out_taken), 64'(0));
        check_eq("bltu_redirect", 64'(out_redirect_pc), 64'(32'h104));
        check_eq("bltu_mispredict", 64'(out_mispredict), 64'(0));
        cycle();

        // Reserved funct3: illegal, not counted
        set_br(3'd3, 32'd5, 32'd5, 32'h200, 32'h8, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("ill_flag", 64'(out_illegal), 64'(1));
        check_eq("ill_taken_mp", 64'({out_taken, out_mispredict}), 64'(0));
        cycle();

        // Back-to-back: 4 branches, exactly 2 mispredicts
`ifdef BRU_PERF_CNT_EN
        perf_clr = 1'b1; cycle(); perf_clr = 1'b0;
`endif
        set_br(3'd0, 32'd7, 32'd7, 32'h1000, 32'h40, 1'b1); cycle();
        set_br(3'd0, 32'd7, 32'd7, 32'h1004, 32'h40, 1'b0); cycle();
        set_br(3'd1, 32'd7, 32'd7, 32'h1008, 32'h40, 1'b0); cycle();
        set_br(3'd1, 32'd7, 32'd9, 32'h100C, 32'h40, 1'b0); cycle();
        check_eq("b2b_last_pc", 64'(out_redirect_pc), 64'(32'h104C));
        in_valid = 1'b0;
        cycle();
`ifdef BRU_PERF_CNT_EN
        check_eq("b2b_branches", 64'(perf_branches), 64'(4));
        check_eq("b2b_mispredicts", 64'(perf_mispredicts), 64'(2));
`endif

        // Backpressure for 3 cycles, then flush
        set_br(3'd5, 32'd3, 32'd2, 32'h300, 32'hFFFF_FFF0, 1'b1);
        cycle();
        out_ready = 1'b0;
        set_br(3'd0, 32'd1, 32'd2, 32'h400, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("bp_hold_target", 64'(out_target), 64'(32'h2F0));
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        cycle();

        // Reset while holding discards the result
        set_br(3'd7, 32'd9, 32'd9, 32'h500, 32'h4, 1'b0);
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("rst_hold_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        cycle();

`ifdef BRU_PERF_CNT_EN
        // Saturation of a 4-bit counter and perf_clr overriding a retire
        perf_clr = 1'b1; cycle(); perf_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_br(3'd0, 32'(i), 32'(i), 32'h600, 32'h8, 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check_eq("sat_branches", 64'(perf_branches), 64'(15));
        set_br(3'd1, 32'd1, 32'd2, 32'h700, 32'h8, 1'b1);
        cycle();
        in_valid = 1'b0; perf_clr = 1'b1;
        cycle();
        perf_clr = 1'b0;
        check_eq("clr_override", 64'(perf_branches), 64'(0));
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            in_funct3     = 3'($urandom_range(0, 7));
            in_a          = $urandom();
            in_b          = ($urandom_range(0, 3) == 0) ? in_a : $urandom();
            if ($urandom_range(0, 3) == 0) in_b = in_a ^ 32'h8000_0000;
            in_pc         = $urandom() & 32'hFFFF_FFFC;
            in_imm        = $urandom();
            in_pred_taken = 1'($urandom_range(0, 1));
`ifdef BRU_PERF_CNT_EN
            perf_clr      = ($urandom_range(0, 49) == 0);
`endif
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch-resolution stage for the RV32 pipeline's EX stage. It evaluates all six conditional-branch conditions, computes the taken target and the redirect PC, and flags mispredictions against the front-end's prediction. Results are held in a single-entry output register behind a valid/ready handshake, with flush support. Optional saturating performance counters track branches and mispredictions.

## Interface
Parameters:
- XLEN, 32: operand and PC width.
- CNT_W, 32: performance counter width. Used only with BRU_PERF_CNT_EN.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kill the held result and block acceptance this cycle.
- in_valid  in  1  branch operands are valid.
- in_ready  out  1  unit can accept a branch this cycle.
- in_funct3  in  3  branch type: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- in_a, in_b  in  XLEN  rs1 and rs2 values.
- in_pc  in  XLEN  branch instruction PC.
- in_imm  in  XLEN  sign-extended B-immediate.
- in_pred_taken  in  1  front-end prediction.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  branch resolved as taken.
- out_target  out  XLEN  in_pc + in_imm.
- out_redirect_pc  out  XLEN  correct next PC.
- out_mispredict  out  1  resolved direction differs from the prediction.
- out_illegal  out  1  in_funct3 is 2 or 3.
- perf_clr  in  1  clear both counters. Present only with BRU_PERF_CNT_EN.
- perf_branches  out  CNT_W  count of retired branches. Present only with BRU_PERF_CNT_EN.
- perf_mispredicts  out  CNT_W  count of retired mispredictions. Present only with BRU_PERF_CNT_EN.

## Operation
- in_ready = !flush && (!out_valid || out_ready). This is combinational.
- Accept occurs when in_valid && in_ready. On accept, the result register loads all out_* fields and sets out_valid = 1.
- Compare rules:
  - Signed compares use two's complement over XLEN bits.
  - Unsigned compares use magnitude.
  - BEQ/BNE test equality.
- funct3 of 2 or 3 gives out_illegal = 1, out_taken = 0 and out_mispredict = 0.
- Arithmetic is modulo 2^XLEN with no overflow flag:
  - out_target = in_pc + in_imm.
  - out_redirect_pc = out_taken ? out_target : in_pc + 4.
- out_mispredict = (out_taken != in_pred_taken) && !out_illegal.
- Retire occurs when out_valid && out_ready && !flush.
  - With retire and no accept, out_valid clears next cycle.
  - With retire and accept in the same cycle, the new result loads and there is no bubble.
- Flush:
  - out_valid = 0 next cycle, regardless of out_ready.
  - No accept occurs that cycle; in_ready is forced to 0.
  - The held result is not retired and not counted.
- Hold: while out_valid && !out_ready, every out_* field stays stable.
- Reset: out_valid, out_taken, out_mispredict and out_illegal are 0; out_target and out_redirect_pc are 0; counters are 0. Reset mid-hold discards the held result.

## Timing
- Latency is 1 cycle: accept at edge N gives out_valid high after edge N.
- Throughput is 1 branch per cycle while out_ready is held high.
- No combinational path runs from in_* to out_*. The only combinational output is in_ready, which depends on flush, out_valid and out_ready.
- Priority, highest first: rst_n low, then flush, then accept/retire.

## Configuration
- BRU_PERF_CNT_EN defined:
  - perf_clr, perf_branches and perf_mispredicts exist.
  - On each retire of a non-illegal result, perf_branches increments by 1.
  - perf_mispredicts increments by 1 when that result also has out_mispredict = 1.
  - Both counters saturate at all-ones.
  - perf_clr clears both counters next cycle and overrides a same-cycle increment.
- BRU_PERF_CNT_EN undefined: the three ports and both counters are absent. All other behaviour is identical.

## Structure
- Package bru_pkg holds:
  - the branch funct3 encodings (BR_EQ=0, BR_NE=1, BR_LT=4, BR_GE=5, BR_LTU=6, BR_GEU=7);
  - a result struct (taken, target, redirect_pc, mispredict, illegal).
- One combinational sub-module, bru_cmp (XLEN parameter), computes taken and illegal from funct3, a and b. The top level holds the handshake, the result register and the counters.

## Test plan
- BLT, a=0xFFFFFFFF, b=1, pc=0x100, imm=0x20, pred=0 → out_taken=1, target=0x120, redirect=0x120, mispredict=1, one cycle after accept.
- BLTU with the same operands, pred=0 → taken=0, redirect=0x104, mispredict=0.
- funct3=3 → illegal=1, taken=0, mispredict=0. With BRU_PERF_CNT_EN, perf_branches is unchanged after retire.
- Back-to-back, out_ready tied high:
  - input: 4 branches, predictions chosen so exactly 2 mispredict;
  - required: in_ready=1 throughout, outputs in order with no bubble;
  - required with BRU_PERF_CNT_EN: perf_branches=4, perf_mispredicts=2.
- Backpressure and flush sequence:
  - Hold out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - Then assert flush → out_valid=0 next cycle, counters unchanged.
- With BRU_PERF_CNT_EN and CNT_W=4:
  - retire 16 branches → perf_branches=15, saturated;
  - perf_clr asserted together with a retiring branch → perf_branches=0.
